// File: rtl/fetch_unit.sv
// fetch_unit: IF stage - owns PCF, issues single-outstanding imem reads,
// buffers returned instructions in a small FIFO toward decode.
module fetch_unit #(
  parameter int DPW = 32,
  parameter logic [DPW-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic           clk_i,
  input  logic           arst_ni,
  input  logic [DPW-1:0] pc_next_i,
  input  logic           redirect_i,
  input  logic           stall_i,
  output logic [DPW-1:0] pcf_o,
  output logic           imem_req_valid_o,
  input  logic           imem_req_ready_i,
  output logic [DPW-1:0] imem_addr_o,
  input  logic           imem_rsp_valid_i,
  input  logic [DPW-1:0] imem_rsp_data_i,
  output logic           instr_valid_o,
  input  logic           instr_ready_i,
  output logic [DPW-1:0] instr_o,
  output logic [DPW-1:0] instr_pc_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LP_DEPTH = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
  state_t r_state, w_state_nx;
  logic [DPW-1:0] r_pcf, r_tag_pc;
  logic [DPW-1:0] r_mem_instr [DEPTH];
  logic [DPW-1:0] r_mem_pc [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0] r_count, w_count_nx;
  logic w_accept, w_push, w_pop;
  assign w_accept = (r_state == REQ) && imem_req_ready_i;
  assign w_push = (r_state == WAIT) && imem_rsp_valid_i && !redirect_i;
  assign w_pop = (r_count != '0) && instr_ready_i && !redirect_i;
  assign w_count_nx = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
  // issuing only while a slot is free reserves room for the one outstanding response
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: w_state_nx = (!stall_i && (r_count < LP_DEPTH) && !redirect_i) ? REQ : IDLE;
      REQ:  w_state_nx = redirect_i ? (imem_req_ready_i ? DROP : IDLE) : (imem_req_ready_i ? WAIT : REQ);
      WAIT: w_state_nx = !imem_rsp_valid_i ? (redirect_i ? DROP : WAIT) :
                         (!stall_i && (w_count_nx < LP_DEPTH) && !redirect_i) ? REQ : IDLE;
      DROP: w_state_nx = imem_rsp_valid_i ? IDLE : DROP;
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= IDLE;
      r_pcf <= RESET_PC;
      r_tag_pc <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nx;
      if (redirect_i || w_accept) r_pcf <= pc_next_i;
      if (w_accept) r_tag_pc <= r_pcf;
      r_wptr <= redirect_i ? '0 : r_wptr + PW'(w_push);
      r_rptr <= redirect_i ? '0 : r_rptr + PW'(w_pop);
      r_count <= redirect_i ? '0 : w_count_nx;
    end
  end
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_instr[r_wptr] <= imem_rsp_data_i;
      r_mem_pc[r_wptr] <= r_tag_pc;
    end
  end
  assign pcf_o = r_pcf;
  assign imem_addr_o = r_pcf;
  assign imem_req_valid_o = (r_state == REQ);
  assign instr_valid_o = (r_count != '0);
  assign instr_o = r_mem_instr[r_rptr];
  assign instr_pc_o = r_mem_pc[r_rptr];
endmodule
